// File: rtl/c17_chk_pkg.sv
// Shared types and constants for the c17 response checker and its MISR.
package c17_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    // Plain-vector state codes keep the FSM readable by older tools.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/c17_response_checker_if.sv
// Response-side bus between the stimulus/golden source (master) and the checker (slave).
interface c17_response_checker_if #(
    parameter int OUT_WIDTH = 2,
    parameter int ADDR_W    = 5
);
    logic                 start;
    logic                 resp_valid;
    logic [OUT_WIDTH-1:0] resp;
    logic [ADDR_W-1:0]    exp_addr;
    logic [OUT_WIDTH-1:0] exp_data;

    modport master (
        output start,
        output resp_valid,
        output resp,
        output exp_data,
        input  exp_addr
    );

    modport slave (
        input  start,
        input  resp_valid,
        input  resp,
        input  exp_data,
        output exp_addr
    );
endinterface

// File: rtl/c17_resp_misr.sv
// Serial-shift MISR that folds each accepted response into a running signature.
module c17_resp_misr
    import c17_chk_pkg::*;
#(
    parameter int DIN_W = 2,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Clear wins over accumulate so a restart never folds in a stale sample.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17_response_checker.sv
// Compares c17 responses against golden vectors and reports error count, first failure and pass.
// Defining RESP_MISR_EN adds a MISR signature output over all accepted responses.
module c17_response_checker
    import c17_chk_pkg::*;
#(
    parameter int OUT_WIDTH  = 2,
    parameter int VEC_LENGTH = 30,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16,
    parameter int SIG_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    c17_response_checker_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_fail_valid,
    output logic [ADDR_W-1:0]    first_fail_idx
`ifdef RESP_MISR_EN
    ,
    output logic [SIG_W-1:0]     signature
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LENGTH - 1);

    if (((2 ** ADDR_W) < VEC_LENGTH) || (SIG_W < 2) || (SIG_W < OUT_WIDTH)) begin : g_bad_cfg
        $error("c17_response_checker: ADDR_W too small for VEC_LENGTH or SIG_W too small");
    end

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              ff_valid_q,  ff_valid_d;
    logic [ADDR_W-1:0] ff_idx_q,    ff_idx_d;

    logic start_run;
    logic sample;
    logic mismatch;

    assign start_run = bus.start && (state_q != ST_RUN);
    assign sample    = bus.resp_valid && (state_q == ST_RUN);

    // A start outside RUN clears all per-run results on the same edge that enters RUN.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_count_d = err_count_q;
        ff_valid_d  = ff_valid_q;
        ff_idx_d    = ff_idx_q;
        mismatch    = |(bus.resp ^ bus.exp_data);

        if (start_run) begin
            state_d     = ST_RUN;
            idx_d       = '0;
            err_count_d = '0;
            ff_valid_d  = 1'b0;
            ff_idx_d    = '0;
        end else if (sample) begin
            if (mismatch) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = idx_q;
                end
            end
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                state_d = ST_DONE;
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            err_count_q <= '0;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_count_q <= err_count_d;
            ff_valid_q  <= ff_valid_d;
            ff_idx_q    <= ff_idx_d;
        end
    end

    assign bus.exp_addr     = idx_q;
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_count_q == '0);
    assign err_count        = err_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;

`ifdef RESP_MISR_EN
    c17_resp_misr #(
        .DIN_W (OUT_WIDTH),
        .SIG_W (SIG_W)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .en    (sample),
        .din   (bus.resp),
        .sig   (signature)
    );
`endif

endmodule

// File: tb/tb_c17_response_checker.sv
// Randomized bench for c17_response_checker: a default-width DUT and a CNT_W=2 twin run in lockstep.
module tb_c17_response_checker;

    localparam int VEC = 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    c17_response_checker_if #(.OUT_WIDTH(2), .ADDR_W(5)) bus  ();
    c17_response_checker_if #(.OUT_WIDTH(2), .ADDR_W(5)) bus2 ();

    logic [1:0] golden [32];

    assign bus.exp_data    = golden[bus.exp_addr];
    assign bus2.start      = bus.start;
    assign bus2.resp_valid = bus.resp_valid;
    assign bus2.resp       = bus.resp;
    assign bus2.exp_data   = golden[bus2.exp_addr];

    logic        busy, done, pass, ffv;
    logic [15:0] err_count;
    logic [4:0]  ffi;
    logic        busy2, done2, pass2, ffv2;
    logic [1:0]  err2;
    logic [4:0]  ffi2;
`ifdef RESP_MISR_EN
    logic [15:0] sig, sig2;
`endif

    c17_response_checker #(
        .OUT_WIDTH(2), .VEC_LENGTH(VEC), .ADDR_W(5), .CNT_W(16), .SIG_W(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (ffv),
        .first_fail_idx   (ffi)
`ifdef RESP_MISR_EN
        ,
        .signature        (sig)
`endif
    );

    c17_response_checker #(
        .OUT_WIDTH(2), .VEC_LENGTH(VEC), .ADDR_W(5), .CNT_W(2), .SIG_W(16)
    ) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_count        (err2),
        .first_fail_valid (ffv2),
        .first_fail_idx   (ffi2)
`ifdef RESP_MISR_EN
        ,
        .signature        (sig2)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},     32'(busy),         32'd0);
        checkOutput({tag, "_done"},     32'(done),         32'd0);
        checkOutput({tag, "_pass"},     32'(pass),         32'd0);
        checkOutput({tag, "_err"},      32'(err_count),    32'd0);
        checkOutput({tag, "_ffv"},      32'(ffv),          32'd0);
        checkOutput({tag, "_ffi"},      32'(ffi),          32'd0);
        checkOutput({tag, "_addr"},     32'(bus.exp_addr), 32'd0);
        checkOutput({tag, "_sat_err"},  32'(err2),         32'd0);
        checkOutput({tag, "_sat_busy"}, 32'(busy2),        32'd0);
`ifdef RESP_MISR_EN
        checkOutput({tag, "_sig"},      32'(sig),          32'd0);
`endif
    endtask

    function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [1:0] r);
        logic [15:0] n;
        n = 16'((32'(s) * 2) & 32'hFFFF);
        if (s >= 16'h8000) n = n ^ 16'h1021;
        return n ^ {14'd0, r};
    endfunction

    // validMode: 0 = every cycle, 1 = alternating 1010..., 2 = random gaps.
    // abortAt >= 0 pulls rst_n low once that many samples have been accepted.
    task automatic applyStimulus(input logic [29:0] badMask, input int validMode, input int abortAt);
        logic [1:0]  respArr [VEC];
        logic [15:0] expSig;
        int          k, budget, errs, first, satErr;
        bit          v;

        for (int i = 0; i < VEC; i++) begin
            golden[i]  = 2'($urandom);
            respArr[i] = badMask[i] ? (golden[i] ^ 2'($urandom_range(1, 3))) : golden[i];
        end

        bus.start      = 1'b1;
        bus.resp_valid = 1'($urandom);
        bus.resp       = 2'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;

        errs = 0; first = -1; k = 0; budget = 0; expSig = 16'd0;
        checkOutput("start_busy",    32'(busy), 32'd1);
        checkOutput("start_err",     32'(err_count), 32'd0);
        checkOutput("start_sat_err", 32'(err2), 32'd0);
        checkOutput("start_ffv",     32'(ffv), 32'd0);
`ifdef RESP_MISR_EN
        checkOutput("start_sig",     32'(sig), 32'd0);
`endif

        while (k < VEC && budget < 1000) begin
            case (validMode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.resp_valid = v;
            bus.resp       = v ? respArr[k] : 2'($urandom);
            bus.start      = ($urandom_range(0, 9) == 0);
            checkOutput("exp_addr", 32'(bus.exp_addr), 32'(k));
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (v) begin
                if (respArr[k] != golden[k]) begin
                    errs++;
                    if (first < 0) first = k;
                end
                expSig = misrStep(expSig, respArr[k]);
                k++;
            end
            budget++;
            satErr = (errs > 3) ? 3 : errs;
            checkOutput("err_count", 32'(err_count), 32'(errs));
            checkOutput("sat_err",   32'(err2), 32'(satErr));
            checkOutput("ffv",       32'(ffv), 32'(first >= 0));
            checkOutput("ffi",       32'(ffi), 32'((first < 0) ? 0 : first));
            checkOutput("busy",      32'(busy), 32'(k < VEC));
            checkOutput("done",      32'(done), 32'(k == VEC));
            if (abortAt >= 0 && k == abortAt) begin
                #2 rst_n = 1'b0;
                #1 checkIdle("abort");
                #2 rst_n = 1'b1;
                bus.resp_valid = 1'b0;
                return;
            end
        end
        if (k < VEC) checkOutput("timeout_samples", 32'(k), 32'(VEC));

        checkOutput("pass",      32'(pass), 32'(errs == 0));
        checkOutput("sat_pass",  32'(pass2), 32'(errs == 0));
        checkOutput("done_addr", 32'(bus.exp_addr), 32'd0);
`ifdef RESP_MISR_EN
        checkOutput("sig",       32'(sig), 32'(expSig));
`endif

        // Results must hold in DONE regardless of resp_valid.
        repeat (3) begin
            bus.resp_valid = 1'b1;
            bus.resp       = 2'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_done", 32'(done), 32'd1);
            checkOutput("hold_err",  32'(err_count), 32'(errs));
            checkOutput("hold_addr", 32'(bus.exp_addr), 32'd0);
`ifdef RESP_MISR_EN
            checkOutput("hold_sig",  32'(sig), 32'(expSig));
`endif
        end
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp       = 2'd0;
        for (int i = 0; i < 32; i++) golden[i] = 2'd0;

        repeat (2) @(posedge clk);
        #1 checkIdle("reset");
        rst_n = 1'b1;

        bus.resp_valid = 1'b1;
        bus.resp       = 2'd3;
        @(posedge clk); #1;
        checkIdle("idle_ignores_valid");
        bus.resp_valid = 1'b0;

        $display("[TB] all-match run");
        applyStimulus(30'd0, 0, -1);
        $display("[TB] corrupt idx 7 and 20");
        applyStimulus(30'h0010_0080, 0, -1);
        $display("[TB] alternating resp_valid");
        applyStimulus(30'($urandom), 1, -1);
        $display("[TB] reset at idx 12");
        applyStimulus(30'($urandom), 2, 12);
        applyStimulus(30'($urandom), 2, -1);
        $display("[TB] all mismatched, saturation on narrow counter");
        applyStimulus('1, 0, -1);
        applyStimulus(30'd0, 2, -1);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(30'($urandom) & 30'($urandom), 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
